calc_arb_mux: RTL and testbench
===============================

CALC_ARB_MUX -- requirements
Module: calc_arb_mux

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter M, default 32: data bit width per channel.
REQ-003 SHALL have parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority with channel 0 highest.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, N: bit i set means channel i offers data.
REQ-007 SHALL have port in_data, input, N*M: channel i data occupies bits [i*M+M-1 : i*M].
REQ-008 SHALL have port in_ready, output, N: bit i set means channel i data is accepted this cycle.
REQ-009 SHALL have port out_valid, output, 1: output register holds a valid word.
REQ-010 SHALL have port out_data, output, M: registered selected data.
REQ-011 SHALL have port out_sel, output, S = max(1, clog2(N)): index of the channel that supplied out_data.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the word this cycle.
REQ-013 SHALL have port xfer_count, output, 16: number of input transfers accepted since reset, wrapping.

Function
REQ-014 SHALL define load = !out_valid | out_ready; an output transfer occurs when out_valid & out_ready.
REQ-015 SHALL compute a one-hot combinational grant over in_valid, and drive in_ready = grant & {N{load}}, so at most one in_ready bit is set in any cycle.
REQ-016 SHALL drive in_ready[i] low whenever in_valid[i] is low.
REQ-017 SHALL, on a cycle with load=1 and any in_valid set, register out_data, out_sel and out_valid=1 from the granted channel, giving 1-cycle latency from acceptance to out_valid.
REQ-018 SHALL, on a cycle with load=1 and no in_valid set, clear out_valid; out_data and out_sel hold their previous values.
REQ-019 SHALL, on a cycle with load=0, hold out_valid, out_data and out_sel unchanged, with in_ready all zero.
REQ-020 SHALL sustain 1 word/cycle when out_ready is held high and requests are continuous; a simultaneous output drain and new acceptance are both legal in the same cycle.
REQ-021 SHALL, in MODE=0, keep a priority pointer ptr (S bits, reset 0) and grant the first requesting channel at or after ptr, searching upward with wrap from N-1 to 0.
REQ-022 SHALL, in MODE=0, set ptr to (granted index + 1) mod N only on cycles where a transfer is accepted; ptr holds otherwise.
REQ-023 SHALL, in MODE=1, grant the lowest-index requesting channel; ptr is unused and stays 0.
REQ-024 SHALL ignore in_data of non-granted channels, and SHALL never let a channel index >= N appear on out_sel.
REQ-025 SHALL increment xfer_count by 1 on each accepted input transfer, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL require no stability of in_valid from the upstream side; a request withdrawn before acceptance is simply not granted.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously on assertion), force out_valid=0, out_data=0, out_sel=0, ptr=0, xfer_count=0; in_ready=0 during reset.
REQ-028 SHALL discard any word held in the output register when reset is asserted mid-operation; the first acceptance after release follows REQ-021 from ptr=0.
REQ-029 SHALL accept no input on the first clk edge coinciding with or preceding rst_n deassertion.

Verification (N=4, M=32)
REQ-030 SHALL verify single request: in_valid=0100, in_data ch2=0xDEADBEEF, out_ready=1 -> in_ready=0100 for one cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2, xfer_count=1.
REQ-031 SHALL verify round-robin fairness (MODE=0): in_valid=1111 held, out_ready=1 -> grant order 0,1,2,3,0; one word per cycle; xfer_count=5 after 5 cycles.
REQ-032 SHALL verify fixed priority (MODE=1): in_valid=1010 held, out_ready=1 -> channel 1 granted every cycle, channel 3 never.
REQ-033 SHALL verify backpressure: out_valid=1 with ch0 word 0x11, out_ready=0 for 3 cycles, in_valid=0011 -> in_ready=0000 and out_data=0x11 stable; on out_ready=1, same-cycle acceptance of ch1 (ptr=1), next out_sel=1.
REQ-034 SHALL verify drain-to-empty: a single word, then in_valid=0000 with out_ready=1 -> out_valid falls to 0 one cycle after the transfer; out_data holds.
REQ-035 SHALL verify async reset mid-stream: rst_n pulled low between edges during traffic -> out_valid=0, xfer_count=0 immediately; after release with in_valid=1111 the first grant is channel 0.

Source files
------------

// File: rtl/calc_arb_mux.sv
// N-channel arbiter feeding a single registered output stage.
// Round-robin (MODE=0) or fixed priority with channel 0 highest (MODE=1).
module calc_arb_mux #(
  parameter int N    = 4,
  parameter int M    = 32,
  parameter int MODE = 0,
  localparam int S   = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*M-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [M-1:0]   out_data,
  output logic [S-1:0]   out_sel,
  input  logic           out_ready,
  output logic [15:0]    xfer_count
);

  // Handshake: a word moves on any port only in a cycle where its valid and
  // ready are both high at the rising edge. Ready never depends on the word.
  // The output register may drain and reload in the same cycle.
  logic [S-1:0] ptr;
  logic [S-1:0] grant_idx;
  logic [N-1:0] grant;
  logic [N-1:0] req_rot;
  logic [M-1:0] sel_data;
  logic         found;
  logic         load;
  logic         active;
  logic         accept;
  int           chan;

  assign load     = !out_valid || out_ready;
  assign accept   = active && load && found;
  assign in_ready = grant & {N{active && load}};

  // Rotate the request vector so that bit 0 is the channel at ptr; the first
  // set bit is then the winner. In fixed-priority mode ptr stays 0.
  always_comb begin
    req_rot   = N'({in_valid, in_valid} >> ptr);
    found     = 1'b0;
    grant_idx = '0;
    chan      = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        chan  = int'(ptr) + k;
        if (chan >= N) chan = chan - N;
        grant_idx = S'(chan);
      end
    end
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int c = 0; c < N; c++) begin
      grant[c] = found && (grant_idx == S'(c));
      if (grant[c]) sel_data = in_data[c*M +: M];
    end
  end

  // Held low through the first edge after reset release, so no transfer can
  // be accepted on an edge that coincides with deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      ptr        <= '0;
      xfer_count <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_sel    <= grant_idx;
        xfer_count <= xfer_count + 16'd1;
        if (MODE == 0) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
      end else if (load) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_arb_mux.sv
// Bench for calc_arb_mux: one round-robin and one fixed-priority instance
// share stimulus; directed scenarios plus randomized traffic against a model.
module tb_calc_arb_mux;
  localparam int N = 4;
  localparam int M = 32;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*M-1:0] in_data = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0] rr_in_ready, fp_in_ready;
  logic         rr_out_valid, fp_out_valid;
  logic [M-1:0] rr_out_data, fp_out_data;
  logic [S-1:0] rr_out_sel, fp_out_sel;
  logic [15:0]  rr_xfer_count, fp_xfer_count;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  calc_arb_mux #(.N(N), .M(M), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready), .xfer_count(rr_xfer_count)
  );

  calc_arb_mux #(.N(N), .M(M), .MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready), .xfer_count(fp_xfer_count)
  );

  // reference model: index 0 = round-robin instance, 1 = fixed priority
  int           m_ptr[2];
  logic         m_ov[2];
  logic [M-1:0] m_od[2];
  int           m_os[2];
  int           m_cnt[2];
  logic [S+M-1:0] exp_q[$];

  function automatic int exp_grant(int inst);
    int start;
    int c;
    start = (inst == 0) ? m_ptr[0] : 0;
    for (int k = 0; k < N; k++) begin
      c = (start + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(int inst);
    int g;
    logic [N-1:0] one;
    one = 1;
    g = exp_grant(inst);
    if (g >= 0 && (!m_ov[inst] || out_ready)) return one << g;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_ov[i] = 1'b0; m_od[i] = '0; m_os[i] = 0; m_cnt[i] = 0;
    end
    exp_q.delete();
  endtask

  // advance one clock and apply the model's state update for that edge
  task automatic tick();
    int g[2];
    logic ld[2];
    logic [M-1:0] d[2];
    for (int i = 0; i < 2; i++) begin
      g[i]  = exp_grant(i);
      ld[i] = !m_ov[i] || out_ready;
      d[i]  = (g[i] >= 0) ? in_data[g[i]*M +: M] : '0;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (ld[i] && g[i] >= 0) begin
        m_ov[i]  = 1'b1;
        m_od[i]  = d[i];
        m_os[i]  = g[i];
        m_cnt[i] = (m_cnt[i] + 1) % 65536;
        if (i == 0) begin
          m_ptr[0] = (g[i] + 1) % N;
          exp_q.push_back({S'(g[i]), d[i]});
        end
      end else if (ld[i]) begin
        m_ov[i] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // driver tasks
  task automatic set_ch(int ch, logic [M-1:0] val);
    in_data[ch*M +: M] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    in_valid = '1;
    #1;
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", rr_out_valid); end
    checks++; if (rr_out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", rr_out_data); end
    checks++; if (rr_out_sel !== '0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", rr_out_sel); end
    checks++; if (rr_xfer_count !== 16'd0) begin errors++; $display("FAIL reset_xfer got %0d want 0", rr_xfer_count); end
    checks++; if (rr_in_ready !== '0) begin errors++; $display("FAIL reset_rr_in_ready got %b want 0000", rr_in_ready); end
    checks++; if (fp_in_ready !== '0) begin errors++; $display("FAIL reset_fp_in_ready got %b want 0000", fp_in_ready); end
    checks++; if (fp_out_valid !== 1'b0) begin errors++; $display("FAIL reset_fp_out_valid got %0b want 0", fp_out_valid); end
    repeat (2) @(negedge clk);
    checks++; if (rr_in_ready !== '0 || rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold in_ready %b out_valid %0b want 0000/0", rr_in_ready, rr_out_valid); end
    in_valid = '0;
    rst_n = 1'b1;
    model_reset();
    tick();
    #1;
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %0b want 0", rr_out_valid); end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, $urandom());
    set_ch(2, 32'hDEADBEEF);
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b want 0100", rr_in_ready); end
    checks++; if (fp_in_ready !== 4'b0100) begin errors++; $display("FAIL single_fp_in_ready got %b want 0100", fp_in_ready); end
    tick();
    in_valid = '0;
    #1;
    checks++; if (rr_in_ready !== '0) begin errors++; $display("FAIL single_ready_drop got %b want 0000", rr_in_ready); end
    checks++; if (rr_out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b want 1", rr_out_valid); end
    checks++; if (rr_out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_out_data got %h want deadbeef", rr_out_data); end
    checks++; if (rr_out_sel !== 2'd2) begin errors++; $display("FAIL single_out_sel got %0d want 2", rr_out_sel); end
    checks++; if (rr_xfer_count !== 16'd1) begin errors++; $display("FAIL single_xfer got %0d want 1", rr_xfer_count); end
  endtask

  task automatic test_rr_fair();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] one;
    one = 1;
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 32'hA0 + c);
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rr_in_ready !== (one << order[c])) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", c, rr_in_ready, one << order[c]); end
      checks++; if (fp_in_ready !== 4'b0001) begin errors++; $display("FAIL rr_fp_grant[%0d] got %b want 0001", c, fp_in_ready); end
      tick();
      #1;
      checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== S'(order[c])) begin errors++; $display("FAIL rr_out[%0d] valid %0b sel %0d want 1/%0d", c, rr_out_valid, rr_out_sel, order[c]); end
      checks++; if (rr_out_data !== 32'hA0 + order[c]) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", c, rr_out_data, 32'hA0 + order[c]); end
    end
    checks++; if (rr_xfer_count !== 16'd5) begin errors++; $display("FAIL rr_xfer got %0d want 5", rr_xfer_count); end
    checks++; if (fp_xfer_count !== 16'd5) begin errors++; $display("FAIL rr_fp_xfer got %0d want 5", fp_xfer_count); end
  endtask

  task automatic test_fixed();
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 32'hF0 + c);
    in_valid = 4'b1010;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (fp_in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_grant[%0d] got %b want 0010", c, fp_in_ready); end
      tick();
      #1;
      checks++; if (fp_out_sel !== 2'd1 || fp_out_data !== 32'hF1) begin errors++; $display("FAIL fixed_out[%0d] sel %0d data %h want 1/f1", c, fp_out_sel, fp_out_data); end
    end
    checks++; if (fp_xfer_count !== 16'd4) begin errors++; $display("FAIL fixed_xfer got %0d want 4", fp_xfer_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ch(0, 32'h11);
    set_ch(1, 32'h22);
    in_valid = 4'b0001;
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = 4'b0011;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rr_in_ready !== '0 || fp_in_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d] rr %b fp %b want 0000", c, rr_in_ready, fp_in_ready); end
      checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h11) begin errors++; $display("FAIL bp_hold[%0d] valid %0b data %h want 1/11", c, rr_out_valid, rr_out_data); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_rr got %b want 0010", rr_in_ready); end
    checks++; if (fp_in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_fp got %b want 0001", fp_in_ready); end
    tick();
    #1;
    checks++; if (rr_out_sel !== 2'd1 || rr_out_data !== 32'h22) begin errors++; $display("FAIL bp_next sel %0d data %h want 1/22", rr_out_sel, rr_out_data); end
    checks++; if (rr_xfer_count !== 16'd2) begin errors++; $display("FAIL bp_xfer got %0d want 2", rr_xfer_count); end
  endtask

  task automatic test_drain();
    do_reset();
    set_ch(3, 32'h33);
    in_valid = 4'b1000;
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = '0;
    #1;
    checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h33) begin errors++; $display("FAIL drain_word valid %0b data %h want 1/33", rr_out_valid, rr_out_data); end
    tick();
    #1;
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", rr_out_valid); end
    checks++; if (rr_out_data !== 32'h33 || rr_out_sel !== 2'd3) begin errors++; $display("FAIL drain_hold data %h sel %0d want 33/3", rr_out_data, rr_out_sel); end
  endtask

  task automatic test_random();
    logic [S+M-1:0] exp_word;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid = N'($urandom_range(0, 15));
      for (int c = 0; c < N; c++) set_ch(c, $urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (rr_in_ready !== exp_ready(0)) begin errors++; $display("FAIL rand_rr_ready[%0d] got %b want %b", n, rr_in_ready, exp_ready(0)); end
      checks++; if (fp_in_ready !== exp_ready(1)) begin errors++; $display("FAIL rand_fp_ready[%0d] got %b want %b", n, fp_in_ready, exp_ready(1)); end
      checks++; if (rr_out_valid !== m_ov[0] || rr_out_data !== m_od[0] || rr_out_sel !== S'(m_os[0])) begin errors++; $display("FAIL rand_rr_out[%0d] got %0b/%h/%0d want %0b/%h/%0d", n, rr_out_valid, rr_out_data, rr_out_sel, m_ov[0], m_od[0], m_os[0]); end
      checks++; if (fp_out_valid !== m_ov[1] || fp_out_data !== m_od[1] || fp_out_sel !== S'(m_os[1])) begin errors++; $display("FAIL rand_fp_out[%0d] got %0b/%h/%0d want %0b/%h/%0d", n, fp_out_valid, fp_out_data, fp_out_sel, m_ov[1], m_od[1], m_os[1]); end
      checks++; if (rr_xfer_count !== 16'(m_cnt[0]) || fp_xfer_count !== 16'(m_cnt[1])) begin errors++; $display("FAIL rand_xfer[%0d] got %0d/%0d want %0d/%0d", n, rr_xfer_count, fp_xfer_count, m_cnt[0], m_cnt[1]); end
      if (rr_out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_scoreboard[%0d] got word %h with nothing expected", n, rr_out_data);
        end else begin
          exp_word = exp_q.pop_front();
          if ({rr_out_sel, rr_out_data} !== exp_word) begin errors++; $display("FAIL rand_scoreboard[%0d] got %h want %h", n, {rr_out_sel, rr_out_data}, exp_word); end
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    bit granted;
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, $urandom());
    in_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rr_out_valid !== 1'b0 || rr_xfer_count !== 16'd0) begin errors++; $display("FAIL async_rr valid %0b xfer %0d want 0/0", rr_out_valid, rr_xfer_count); end
    checks++; if (fp_out_valid !== 1'b0 || fp_xfer_count !== 16'd0) begin errors++; $display("FAIL async_fp valid %0b xfer %0d want 0/0", fp_out_valid, fp_xfer_count); end
    checks++; if (rr_in_ready !== '0) begin errors++; $display("FAIL async_in_ready got %b want 0000", rr_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    granted = 1'b0;
    for (int w = 0; w < 4 && !granted; w++) begin
      #1;
      if (rr_in_ready !== '0) granted = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!granted) begin
      errors++; $display("FAIL async_first_grant timeout got 0000 want 0001");
    end else if (rr_in_ready !== 4'b0001 || fp_in_ready !== 4'b0001) begin
      errors++; $display("FAIL async_first_grant rr %b fp %b want 0001", rr_in_ready, fp_in_ready);
    end
    checks++; if (rr_xfer_count !== 16'd0) begin errors++; $display("FAIL async_xfer_restart got %0d want 0", rr_xfer_count); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rr_fair();
    test_fixed();
    test_backpressure();
    test_drain();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
